score_display_ctrl: RTL and testbench

Sequential binary-to-BCD controller that feeds the per-digit 7-segment decoders on the score display. It accepts a binary value on a start strobe and converts it with a shift-and-add-3 (double-dabble) state machine, one bit per clock. It then publishes one BCD nibble per digit plus per-digit show controls with optional leading-zero blanking. It sits between the game score/timer logic and the DIGITS decoder instances.

---
 rtl/score_display_ctrl.sv | 86 ++++++++
 tb/tb_score_display_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/score_display_ctrl.sv
// score_display_ctrl: sequential double-dabble binary-to-BCD converter driving per-digit 7-segment decoders
module score_display_ctrl #(
    parameter int DIGITS  = 4,
    parameter int BIN_W   = 14,
    parameter int MAX_VAL = 9999
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      value,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   digit_bcd,
    output logic [DIGITS-1:0]     digit_show
);
    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);
    localparam logic [BIN_W-1:0] MAXV = BIN_W'(MAX_VAL);

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    state_t          state;
    logic [SW-1:0]   scratch;
    logic [SW-1:0]   adj;
    logic [BIN_W-1:0] sh;
    logic [CW-1:0]   cnt;
    logic            ovf;
    logic [DIGITS-1:0] show;
    logic            any;

    // add-3 correction per nibble and leading-zero blanking mask from the finished scratch
    always_comb begin
        adj  = scratch;
        show = '0;
        any  = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            adj[4*i +: 4] = scratch[4*i +: 4] >= 4'd5 ? scratch[4*i +: 4] + 4'd3 : scratch[4*i +: 4];
            any = any | (|scratch[4*i +: 4]);
            show[i] = !blank_lz || any || i == 0;
        end
    end

    // conversion FSM; published outputs change only when leaving LOAD
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            digit_bcd  <= '0;
            digit_show <= DIGITS'(1);
            scratch    <= '0;
            sh         <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    sh      <= value > MAXV ? MAXV : value;
                    ovf     <= value > MAXV;
                    scratch <= '0;
                    cnt     <= CW'(BIN_W);
                    busy    <= 1'b1;
                    state   <= CONV;
                end
                CONV: begin
                    {scratch, sh} <= {adj, sh} << 1;
                    cnt           <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= LOAD;
                end
                LOAD: begin
                    digit_bcd  <= scratch;
                    digit_show <= show;
                    overflow   <= ovf;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_score_display_ctrl.sv
// tb_score_display_ctrl: directed self-checking bench for score_display_ctrl
module tb_score_display_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [13:0] value = '0;
    logic        blank_lz = 1'b0;
    logic        busy, done, overflow;
    logic [15:0] digit_bcd;
    logic [3:0]  digit_show;
    int checks = 0;
    int errors = 0;

    score_display_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .value(value), .blank_lz(blank_lz),
        .busy(busy), .done(done), .overflow(overflow),
        .digit_bcd(digit_bcd), .digit_show(digit_show)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // launch a conversion, then wait for done; leaves the bench in the done cycle
    task automatic convert(input logic [13:0] v, input logic bl);
        logic [15:0] prev;
        bit held;
        int n;
        prev = digit_bcd;
        held = 1;
        start = 1'b1;
        value = v;
        blank_lz = bl;
        tick;
        start = 1'b0;
        value = '1;
        check("busy_on", busy, 1);
        n = 0;
        while (!done && n < 40) begin
            if (digit_bcd !== prev) held = 0;
            tick;
            n++;
        end
        check("latency", n, 15);
        check("held", held, 1);
        check("busy_off", busy, 0);
    endtask

    initial begin
        logic [15:0] prev;
        bit held;
        int ndone;
        tick;
        tick;
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", overflow, 0);
        check("rst_bcd", digit_bcd, 16'h0000);
        check("rst_show", digit_show, 4'b0001);

        convert(14'd1234, 1'b0);
        check("1234_bcd", digit_bcd, 16'h1234);
        check("1234_show", digit_show, 4'b1111);
        check("1234_ovf", overflow, 0);
        tick;
        check("done_pulse", done, 0);

        convert(14'd7, 1'b1);
        check("7_bcd", digit_bcd, 16'h0007);
        check("7_show", digit_show, 4'b0001);
        convert(14'd0, 1'b1);
        check("0_bcd", digit_bcd, 16'h0000);
        check("0_show", digit_show, 4'b0001);
        convert(14'd1005, 1'b1);
        check("1005_bcd", digit_bcd, 16'h1005);
        check("1005_show", digit_show, 4'b1111);
        convert(14'd50, 1'b1);
        check("50_bcd", digit_bcd, 16'h0050);
        check("50_show", digit_show, 4'b0011);

        convert(14'd12000, 1'b0);
        check("sat_bcd", digit_bcd, 16'h9999);
        check("sat_ovf", overflow, 1);
        convert(14'd42, 1'b0);
        check("42_bcd", digit_bcd, 16'h0042);
        check("42_ovf", overflow, 0);
        tick;

        prev = digit_bcd;
        held = 1;
        ndone = 0;
        start = 1'b1;
        value = 14'd300;
        tick;
        for (int c = 1; c <= 20; c++) begin
            start = (c == 3 || c == 14);
            value = start ? 14'd888 : 14'd0;
            tick;
            if (done) begin
                ndone++;
                check("stray_lat", c, 15);
            end else if (ndone == 0 && digit_bcd !== prev) held = 0;
        end
        start = 1'b0;
        check("stray_ndone", ndone, 1);
        check("stray_held", held, 1);
        check("stray_bcd", digit_bcd, 16'h0300);

        convert(14'd21, 1'b0);
        check("b2b1_bcd", digit_bcd, 16'h0021);
        convert(14'd88, 1'b0);
        check("b2b2_bcd", digit_bcd, 16'h0088);
        tick;

        start = 1'b1;
        value = 14'd5555;
        tick;
        start = 1'b0;
        repeat (5) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_bcd", digit_bcd, 16'h0000);
        check("abort_show", digit_show, 4'b0001);
        check("abort_ovf", overflow, 0);
        ndone = 0;
        repeat (20) begin
            tick;
            if (done || busy) ndone++;
        end
        check("abort_quiet", ndone, 0);
        convert(14'd21, 1'b0);
        check("post_bcd", digit_bcd, 16'h0021);
        check("post_show", digit_show, 4'b1111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
